// File: rtl/movimento_scan_if.sv
// Car-controller signal bundle: call inputs and obstruction sensor in,
// floor/state/motor/door indications out.
interface movimento_scan_if #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
);
  logic [N_FLOORS-1:0] req;
  logic                obstruct;
  logic [FLOOR_W-1:0]  floor;
  logic [1:0]          state;
  logic                dir_up;
  logic                motor_up;
  logic                motor_dn;
  logic                door_open;
  logic                arrive;
  logic [N_FLOORS-1:0] pending;

  modport master (
    output req, obstruct,
    input  floor, state, dir_up, motor_up, motor_dn, door_open, arrive, pending
  );

  modport slave (
    input  req, obstruct,
    output floor, state, dir_up, motor_up, motor_dn, door_open, arrive, pending
  );
endinterface

// File: rtl/movimento_scan.sv
// SCAN-order elevator motion controller: latches floor calls, steps the car one
// floor per travel period and times the door with an obstruction-aware counter.
module movimento_scan #(
  parameter int N_FLOORS      = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input logic            clk,
  input logic            rst,
  movimento_scan_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MOVE_UP = 2'd1,
    S_MOVE_DN = 2'd2,
    S_DOOR    = 2'd3
  } state_t;

  localparam int TCNT_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DCNT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0]  DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  state_t              r_state;
  logic [FLOOR_W-1:0]  r_floor;
  logic                r_dir_up;
  logic [N_FLOORS-1:0] r_pending;
  logic                r_arrive;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [DCNT_W-1:0]   r_dcnt;

  state_t              w_state_nx;
  logic [FLOOR_W-1:0]  w_floor_nx;
  logic                w_dir_nx;
  logic [N_FLOORS-1:0] w_pending_nx;
  logic                w_arrive_nx;
  logic [TCNT_W-1:0]   w_tcnt_nx;
  logic [DCNT_W-1:0]   w_dcnt_nx;

  logic [N_FLOORS-1:0] w_pend_or;
  logic [N_FLOORS-1:0] w_clr;
  logic                w_above;
  logic                w_below;
  logic                w_here;
  logic [FLOOR_W-1:0]  w_floor_up;
  logic [FLOOR_W-1:0]  w_floor_dn;

  assign w_floor_up = r_floor + 1'b1;
  assign w_floor_dn = r_floor - 1'b1;

  // Call summary sees this cycle's requests so a fresh call is acted on at the next edge.
  always_comb begin
    w_pend_or = r_pending | bus.req;
    w_above   = 1'b0;
    w_below   = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(r_floor)) w_above = w_above | w_pend_or[i];
      if (i < int'(r_floor)) w_below = w_below | w_pend_or[i];
    end
    w_here = w_pend_or[r_floor];
  end

  always_comb begin
    w_state_nx  = r_state;
    w_floor_nx  = r_floor;
    w_dir_nx    = r_dir_up;
    w_arrive_nx = 1'b0;
    w_tcnt_nx   = '0;
    w_dcnt_nx   = '0;
    w_clr       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_here) begin
          w_state_nx = S_DOOR;
        end else if (w_above && (r_dir_up || !w_below)) begin
          w_state_nx = S_MOVE_UP;
          w_dir_nx   = 1'b1;
        end else if (w_below) begin
          w_state_nx = S_MOVE_DN;
          w_dir_nx   = 1'b0;
        end
      end
      S_MOVE_UP: begin
        if (r_tcnt == TRAVEL_LAST) begin
          w_floor_nx  = w_floor_up;
          w_arrive_nx = 1'b1;
          if (w_pend_or[w_floor_up])       w_state_nx = S_DOOR;
          else if (w_floor_up == TOP_FLOOR) w_state_nx = S_IDLE;
        end else begin
          w_tcnt_nx = r_tcnt + 1'b1;
        end
      end
      S_MOVE_DN: begin
        if (r_tcnt == TRAVEL_LAST) begin
          w_floor_nx  = w_floor_dn;
          w_arrive_nx = 1'b1;
          if (w_pend_or[w_floor_dn])      w_state_nx = S_DOOR;
          else if (w_floor_dn == '0)      w_state_nx = S_IDLE;
        end else begin
          w_tcnt_nx = r_tcnt + 1'b1;
        end
      end
      S_DOOR: begin
        if (bus.obstruct || bus.req[r_floor]) begin
          w_dcnt_nx = '0;
        end else if (r_dcnt == DOOR_LAST) begin
          // Keep the current sweep direction while calls remain ahead.
          if (w_above && r_dir_up) begin
            w_state_nx = S_MOVE_UP;
          end else if (w_below && !r_dir_up) begin
            w_state_nx = S_MOVE_DN;
          end else if (w_above) begin
            w_state_nx = S_MOVE_UP;
            w_dir_nx   = 1'b1;
          end else if (w_below) begin
            w_state_nx = S_MOVE_DN;
            w_dir_nx   = 1'b0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_dcnt_nx = r_dcnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_state_nx == S_DOOR) w_clr[w_floor_nx] = 1'b1;
    w_pending_nx = w_pend_or & ~w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_floor   <= '0;
      r_dir_up  <= 1'b1;
      r_pending <= '0;
      r_arrive  <= 1'b0;
      r_tcnt    <= '0;
      r_dcnt    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_floor   <= w_floor_nx;
      r_dir_up  <= w_dir_nx;
      r_pending <= w_pending_nx;
      r_arrive  <= w_arrive_nx;
      r_tcnt    <= w_tcnt_nx;
      r_dcnt    <= w_dcnt_nx;
    end
  end

  assign bus.floor     = r_floor;
  assign bus.state     = r_state;
  assign bus.dir_up    = r_dir_up;
  assign bus.motor_up  = (r_state == S_MOVE_UP);
  assign bus.motor_dn  = (r_state == S_MOVE_DN);
  assign bus.door_open = (r_state == S_DOOR);
  assign bus.arrive    = r_arrive;
  assign bus.pending   = r_pending;

endmodule

// File: tb/tb_movimento_scan.sv
// Directed bench for movimento_scan with 4 floors, 4-cycle travel, 3-cycle door.
module tb_movimento_scan;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  movimento_scan_if #(.N_FLOORS(4), .FLOOR_W(2)) bus ();

  movimento_scan #(
    .N_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // The car must never be driven past either end of the shaft.
  always @(negedge clk) begin
    if (!rst)
      check("floor_bound",
            {31'b0, (bus.motor_up && bus.floor == 2'd3) || (bus.motor_dn && bus.floor == 2'd0)},
            32'd0);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.obstruct = 1'b0;
    step(2);
    check("rst_state",   bus.state,   0);
    check("rst_floor",   bus.floor,   0);
    check("rst_dir",     bus.dir_up,  1);
    check("rst_pending", bus.pending, 0);
    check("rst_arrive",  bus.arrive,  0);
    rst = 1'b0;

    // 1: single call to floor 2
    bus.req = 4'b0100;
    step(1);
    bus.req = 4'b0000;
    check("t1_up",       bus.state,    1);
    check("t1_motor",    bus.motor_up, 1);
    check("t1_pend",     bus.pending,  4'b0100);
    step(3);
    check("t1_f0",       bus.floor,    0);
    step(1);
    check("t1_f1",       bus.floor,    1);
    check("t1_arr",      bus.arrive,   1);
    check("t1_pass",     bus.state,    1);
    step(1);
    check("t1_arr_off",  bus.arrive,   0);
    step(3);
    check("t1_f2",       bus.floor,    2);
    check("t1_door",     bus.door_open, 1);
    check("t1_pend0",    bus.pending,  0);
    step(2);
    check("t1_door_hold", bus.door_open, 1);
    step(1);
    check("t1_idle",     bus.state,    0);
    check("t1_pend_end", bus.pending,  0);

    // 2: call at the current floor
    do_reset;
    bus.req = 4'b0001;
    step(1);
    bus.req = 4'b0000;
    check("t2_door",     bus.state,    3);
    check("t2_motors",   {bus.motor_up, bus.motor_dn}, 0);
    check("t2_pend",     bus.pending,  0);
    step(2);
    check("t2_hold",     bus.state,    3);
    check("t2_motors2",  {bus.motor_up, bus.motor_dn}, 0);
    step(1);
    check("t2_idle",     bus.state,    0);

    // 3: sweep up to floor 3, then reverse to serve floor 0
    bus.req = 4'b1000;
    step(1);
    check("t3_up",       bus.state,    1);
    bus.req = 4'b0001;
    step(1);
    bus.req = 4'b0000;
    check("t3_merge",    bus.pending,  4'b1001);
    step(7);
    check("t3_f2",       bus.floor,    2);
    check("t3_f2_state", bus.state,    1);
    check("t3_f2_pend",  bus.pending,  4'b1001);
    step(4);
    check("t3_f3",       bus.floor,    3);
    check("t3_f3_door",  bus.state,    3);
    check("t3_f3_pend",  bus.pending,  4'b0001);
    step(3);
    check("t3_rev",      bus.state,    2);
    check("t3_dir",      bus.dir_up,   0);
    check("t3_motor_dn", bus.motor_dn, 1);
    step(12);
    check("t3_f0",       bus.floor,    0);
    check("t3_f0_door",  bus.state,    3);
    check("t3_f0_pend",  bus.pending,  0);
    step(3);
    check("t3_idle",     bus.state,    0);

    // 4: obstruction holds the door
    bus.req = 4'b0001;
    step(1);
    bus.req = 4'b0000;
    bus.obstruct = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t4_obst_hold", bus.door_open, 1);
    end
    bus.obstruct = 1'b0;
    step(2);
    check("t4_tail",     bus.door_open, 1);
    step(1);
    check("t4_closed",   bus.state,    0);

    // 5: same-floor call on the last door cycle restarts the timer
    bus.req = 4'b0010;
    step(1);
    bus.req = 4'b0000;
    check("t5_up",       bus.state,    1);
    step(4);
    check("t5_f1",       bus.floor,    1);
    check("t5_door",     bus.state,    3);
    check("t5_arr",      bus.arrive,   1);
    step(2);
    check("t5_last",     bus.state,    3);
    bus.req = 4'b0010;
    step(1);
    bus.req = 4'b0000;
    check("t5_retrig",   bus.state,    3);
    check("t5_pend",     bus.pending,  0);
    step(2);
    check("t5_hold",     bus.state,    3);
    step(1);
    check("t5_idle",     bus.state,    0);

    // 6: asynchronous reset while travelling from floor 1 to 2
    do_reset;
    bus.req = 4'b1000;
    step(1);
    bus.req = 4'b0000;
    check("t6_up",       bus.state,    1);
    step(6);
    check("t6_f1",       bus.floor,    1);
    check("t6_moving",   bus.motor_up, 1);
    rst = 1'b1;
    #1;
    check("t6_state",    bus.state,    0);
    check("t6_floor",    bus.floor,    0);
    check("t6_motor",    bus.motor_up, 0);
    check("t6_pend",     bus.pending,  0);
    step(1);
    rst = 1'b0;
    step(2);
    check("t6_after",    bus.state,    0);
    check("t6_after_m",  bus.motor_up, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
